// File: rtl/func_driver_pkg.sv
// Shared types and defaults for the function-unit driver: FSM state encoding,
// operand/result width defaults, default timeout and the response entry layout.
package func_pkg;

   localparam int IN_W_DEF    = 8;
   localparam int OUT_W_DEF   = 10;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_ARM   = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   typedef struct packed {
      logic                 err;
      logic [OUT_W_DEF-1:0] data;
   } rsp_entry_t;

endpackage

// File: rtl/func_driver_result_fifo.sv
// Synchronous result FIFO with a registered head word; DEPTH must be a power of 2.
// An empty FIFO receiving a push presents that word on the next cycle.
module result_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] w_head_next;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_do_pop  = i_pop && (r_count != CW'(0));
   assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

   // Next head word: the entry behind the popped one, or a push landing in an empty slot.
   always_comb begin
      w_head_next = r_head;
      if (w_do_pop) begin
         if (r_count > CW'(1)) begin
            w_head_next = r_mem[r_rd + AW'(1)];
         end else if (w_do_push) begin
            w_head_next = i_push_data;
         end else begin
            w_head_next = '0;
         end
      end else if (w_do_push && (r_count == CW'(0))) begin
         w_head_next = i_push_data;
      end else begin
         w_head_next = r_head;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_push_data;
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         r_head <= w_head_next;
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= r_rd + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_head;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == CW'(0));
   assign o_count = r_count;

endmodule

// File: rtl/func_driver.sv
// Start/busy initiator for the 3*a + 2*cbrt(b) function unit with a result FIFO.
// Optional timeout in ARM/WAIT is enabled by defining FUNC_DRIVER_TIMEOUT_EN.
module func_driver
   import func_pkg::*;
#(
   parameter int IN_W    = IN_W_DEF,
   parameter int OUT_W   = OUT_W_DEF,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IN_W-1:0]  req_a,
   input  logic [IN_W-1:0]  req_b,
   output logic [IN_W-1:0]  fu_a,
   output logic [IN_W-1:0]  fu_b,
   output logic             fu_start,
   input  logic             fu_busy,
   input  logic [OUT_W-1:0] fu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic             rsp_err
);

   localparam int CNT_W = $clog2(DEPTH+1);
`ifdef FUNC_DRIVER_TIMEOUT_EN
   localparam int FIFO_W = OUT_W + 1;
   localparam int TMO_W  = $clog2(TIMEOUT+1);
`else
   localparam int FIFO_W = OUT_W;
`endif

   state_t            r_state;
   state_t            w_next_state;
   logic [IN_W-1:0]   r_a;
   logic [IN_W-1:0]   r_b;
   logic              r_start;
   logic              w_accept;
   logic              w_push;
   logic              w_push_tmo;
   logic              w_tmo_hit;
   logic [OUT_W-1:0]  w_push_val;
   logic [FIFO_W-1:0] w_push_data;
   logic [FIFO_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;

   // A slot is reserved at accept time, so the eventual push cannot overflow.
   assign req_ready = !rst && (r_state == S_IDLE) && (w_count < CNT_W'(DEPTH));
   assign w_accept  = req_valid && req_ready;

`ifdef FUNC_DRIVER_TIMEOUT_EN
   logic [TMO_W-1:0] r_tmo_cnt;

   // Cycle counter for ARM/WAIT, cleared while issuing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_ARM) || (r_state == S_WAIT)) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
         r_tmo_cnt <= r_tmo_cnt;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt >= TMO_W'(TIMEOUT-1));
`else
   assign w_tmo_hit = 1'b0 && (TIMEOUT > 0);
`endif

   // Next state and push request; a real result in WAIT wins over a coincident timeout.
   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      w_push_tmo   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_ISSUE;
            else          w_next_state = S_IDLE;
         end
         S_ISSUE: w_next_state = S_ARM;
         S_ARM: begin
            if (w_tmo_hit) begin
               w_push       = 1'b1;
               w_push_tmo   = 1'b1;
               w_next_state = S_IDLE;
            end else if (fu_busy) begin
               w_next_state = S_WAIT;
            end else begin
               w_next_state = S_ARM;
            end
         end
         S_WAIT: begin
            if (!fu_busy) begin
               w_push       = 1'b1;
               w_next_state = S_IDLE;
            end else if (w_tmo_hit) begin
               w_push       = 1'b1;
               w_push_tmo   = 1'b1;
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, operand hold registers and the one-cycle start pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_start <= (w_next_state == S_ISSUE);
         if (w_accept) begin
            r_a <= req_a;
            r_b <= req_b;
         end
      end
   end

   assign w_push_val = w_push_tmo ? '0 : fu_out;
`ifdef FUNC_DRIVER_TIMEOUT_EN
   assign w_push_data = {w_push_tmo, w_push_val};
   assign rsp_err     = w_head[OUT_W];
   assign rsp_data    = w_head[OUT_W-1:0];
`else
   assign w_push_data = w_push_val;
   assign rsp_err     = 1'b0;
   assign rsp_data    = w_head;
`endif

   result_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push && !w_full),
      .i_push_data (w_push_data),
      .i_pop       (rsp_ready),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   assign rsp_valid = !w_empty;
   assign fu_start  = r_start;
   assign fu_a      = r_a;
   assign fu_b      = r_b;

endmodule

// File: tb/tb_func_driver.sv
// Directed self-checking bench for func_driver with a behavioural start/busy
// function unit (3*a + 2*cbrt(b)) that can be forced to hold busy forever.
module tb_func_driver;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [7:0] fu_a;
   logic [7:0] fu_b;
   logic       fu_start;
   logic       fu_busy;
   logic [9:0] fu_out;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [9:0] rsp_data;
   logic       rsp_err;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   int two_in_row = 0;
   bit prev_v = 1'b0;
   logic [9:0] popped[$];

   int fu_lat = 3;
   bit stuck = 1'b0;
   int fu_cnt;
   logic [7:0] m_a;
   logic [7:0] m_b;

   func_driver #(.IN_W(8), .OUT_W(10), .DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .fu_a(fu_a), .fu_b(fu_b), .fu_start(fu_start), .fu_busy(fu_busy), .fu_out(fu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] fu_calc(input logic [7:0] a, input logic [7:0] b);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
      return 10'(3 * int'(a) + 2 * r);
   endfunction

   // Function unit: busy rises the cycle after start, result written as busy falls.
   always @(posedge clk) begin
      if (rst) begin
         fu_busy <= 1'b0;
         fu_out  <= 10'd0;
         fu_cnt  <= 0;
      end else if (!fu_busy) begin
         if (fu_start) begin
            fu_busy <= 1'b1;
            fu_cnt  <= fu_lat;
            m_a     <= fu_a;
            m_b     <= fu_b;
         end
      end else if (!stuck) begin
         if (fu_cnt == 0) begin
            fu_busy <= 1'b0;
            fu_out  <= fu_calc(m_a, m_b);
         end else begin
            fu_cnt <= fu_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (fu_start) start_cnt++;
      if (rsp_valid && rsp_ready) popped.push_back(rsp_data);
      if (rsp_valid && rsp_ready && prev_v) two_in_row++;
      prev_v = rsp_valid && rsp_ready;
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      req_a = a; req_b = b; req_valid = 1'b1;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         errors++; checks++;
         $display("FAIL send_wait: req_ready=%0b required 1 within %0d cycles", req_ready, n);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic recv(output logic [9:0] d, output logic e);
      int n = 0;
      while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
      if (!rsp_valid) begin
         errors++; checks++;
         $display("FAIL recv_wait: rsp_valid=%0b required 1 within %0d cycles", rsp_valid, n);
      end
      d = rsp_data; e = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_a = 8'd0; req_b = 8'd0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b want 0", req_ready); end
      checks++; if (fu_start !== 1'b0) begin errors++; $display("FAIL rst_fu_start: got %0b want 0", fu_start); end
      checks++; if (fu_a !== 8'd0 || fu_b !== 8'd0) begin errors++; $display("FAIL rst_fu_ab: got %0d/%0d want 0/0", fu_a, fu_b); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
      checks++; if (rsp_data !== 10'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_data: got %0d/%0b want 0/0", rsp_data, rsp_err); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
   endtask

   task automatic test_single();
      logic [9:0] d; logic e; int s0;
      s0 = start_cnt;
      send(8'd10, 8'd27);
      checks++; if (fu_start !== 1'b1) begin errors++; $display("FAIL single_start_cycle: got %0b want 1", fu_start); end
      checks++; if (fu_a !== 8'd10 || fu_b !== 8'd27) begin errors++; $display("FAIL single_fu_ab: got %0d/%0d want 10/27", fu_a, fu_b); end
      recv(d, e);
      checks++; if (d !== 10'd36) begin errors++; $display("FAIL single_data: got %0d want 36", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", e); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", start_cnt - s0); end
   endtask

   task automatic test_boundary();
      int va[4] = '{0, 1, 255, 255};
      int vb[4] = '{0, 8, 255, 1};
      int ex[4] = '{0, 7, 777, 767};
      logic [9:0] d; logic e;
      for (int i = 0; i < 4; i++) send(8'(va[i]), 8'(vb[i]));
      for (int i = 0; i < 4; i++) begin
         recv(d, e);
         checks++; if (d !== 10'(ex[i]) || e !== 1'b0) begin errors++; $display("FAIL boundary_%0d: got %0d/%0b want %0d/0", i, d, e, ex[i]); end
      end
   endtask

   task automatic test_backpressure();
      int ex[5] = '{5, 10, 15, 20, 25};
      logic [9:0] d; logic e; bit saw_ready;
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'(i + 1), 8'((i + 1) * (i + 1) * (i + 1)));
      req_a = 8'd5; req_b = 8'd125; req_valid = 1'b1;
      saw_ready = 1'b0;
      repeat (20) begin
         if (req_ready) saw_ready = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_while_full: got %0b want 0", saw_ready); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %0b want 1", rsp_valid); end
      d = rsp_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (d !== 10'(ex[0])) begin errors++; $display("FAIL bp_data_0: got %0d want %0d", d, ex[0]); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %0b want 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         recv(d, e);
         checks++; if (d !== 10'(ex[i])) begin errors++; $display("FAIL bp_data_%0d: got %0d want %0d", i, d, ex[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int ex[4] = '{18, 23, 28, 39};
      int base; int t0; int n;
      base = popped.size();
      t0 = two_in_row;
      rsp_ready = 1'b1;
      send(8'd6, 8'd0);
      send(8'd7, 8'd1);
      send(8'd8, 8'd8);
      send(8'd9, 8'd216);
      n = 0;
      while (popped.size() < base + 4 && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (popped.size() - base !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", popped.size() - base); end
      for (int i = 0; i < 4; i++) begin
         if (base + i < popped.size()) begin
            checks++; if (popped[base + i] !== 10'(ex[i])) begin errors++; $display("FAIL b2b_data_%0d: got %0d want %0d", i, popped[base + i], ex[i]); end
         end
      end
      checks++; if (two_in_row - t0 !== 0) begin errors++; $display("FAIL b2b_occupancy: consecutive pops %0d want 0", two_in_row - t0); end
   endtask

   task automatic test_reset_mid();
      logic [9:0] d; logic e; int n;
      rsp_ready = 1'b0;
      send(8'd20, 8'd0);
      n = 0;
      while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
      fu_lat = 8;
      send(8'd30, 8'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %0b want 0", rsp_valid); end
      checks++; if (fu_start !== 1'b0) begin errors++; $display("FAIL rmid_fu_start: got %0b want 0", fu_start); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_req_ready: got %0b want 0", req_ready); end
      rst = 1'b0;
      fu_lat = 3;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_release: got %0b want 1", req_ready); end
      @(negedge clk);
      send(8'd2, 8'd64);
      recv(d, e);
      checks++; if (d !== 10'd14 || e !== 1'b0) begin errors++; $display("FAIL rmid_new_txn: got %0d/%0b want 14/0", d, e); end
   endtask

   task automatic test_timeout();
      bit early;
      stuck = 1'b1;
      rsp_ready = 1'b0;
      send(8'd1, 8'd1);
`ifdef FUNC_DRIVER_TIMEOUT_EN
      early = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (rsp_valid) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_early: rsp_valid seen %0b want 0 before 16 cycles", early); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %0b want 1", rsp_valid); end
      checks++; if (rsp_err !== 1'b1 || rsp_data !== 10'd0) begin errors++; $display("FAIL tmo_entry: got err=%0b data=%0d want 1/0", rsp_err, rsp_data); end
`else
      early = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_absent: rsp_valid seen %0b want 0", early); end
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      stuck = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
